// File: rtl/key_selection.sv
// Anubis-128 round-key extraction: K = tau(omega(gamma(kappa))).
// The extraction network is purely combinational; only the round key is registered.
module key_selection #(
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       counter,
  input  logic             load_key,
  input  logic [KEY_W-1:0] evolutioned_key,
  output logic [KEY_W-1:0] round_key
);

  // Anubis S-box (an involution: S(S(x)) = x).
  localparam logic [7:0] SBOX [256] = '{
    8'hA7, 8'hD3, 8'hE6, 8'h71, 8'hD0, 8'hAC, 8'h4D, 8'h79, 8'h3A, 8'hC9, 8'h91, 8'hFC, 8'h1E, 8'h47, 8'h54, 8'hBD,
    8'h8C, 8'hA5, 8'h7A, 8'hFB, 8'h63, 8'hB8, 8'hDD, 8'hD4, 8'hE5, 8'hB3, 8'hC5, 8'hBE, 8'hA9, 8'h88, 8'h0C, 8'hA2,
    8'h39, 8'hDF, 8'h29, 8'hDA, 8'h2B, 8'hA8, 8'hCB, 8'h4C, 8'h4B, 8'h22, 8'hAA, 8'h24, 8'h41, 8'h70, 8'hA6, 8'hF9,
    8'h5A, 8'hE2, 8'hB0, 8'h36, 8'h7D, 8'hE4, 8'h33, 8'hFF, 8'h60, 8'h20, 8'h08, 8'h8B, 8'h5E, 8'hAB, 8'h7F, 8'h78,
    8'h7C, 8'h2C, 8'h57, 8'hD2, 8'hDC, 8'h6D, 8'h7E, 8'h0D, 8'h53, 8'h94, 8'hC3, 8'h28, 8'h27, 8'h06, 8'h5F, 8'hAD,
    8'h67, 8'h5C, 8'h55, 8'h48, 8'h0E, 8'h52, 8'hEA, 8'h42, 8'h5B, 8'h5D, 8'h30, 8'h58, 8'h51, 8'h59, 8'h3C, 8'h4E,
    8'h38, 8'h8A, 8'h72, 8'h14, 8'hE7, 8'hC6, 8'hDE, 8'h50, 8'h8E, 8'h92, 8'hD1, 8'h77, 8'h93, 8'h45, 8'h9A, 8'hCE,
    8'h2D, 8'h03, 8'h62, 8'hB6, 8'hB9, 8'hBF, 8'h96, 8'h6B, 8'h3F, 8'h07, 8'h12, 8'hAE, 8'h40, 8'h34, 8'h46, 8'h3E,
    8'hDB, 8'hCF, 8'hEC, 8'hCC, 8'hC1, 8'hA1, 8'hC0, 8'hD6, 8'h1D, 8'hF4, 8'h61, 8'h3B, 8'h10, 8'hD8, 8'h68, 8'hA0,
    8'hB1, 8'h0A, 8'h69, 8'h6C, 8'h49, 8'hFA, 8'h76, 8'hC4, 8'h9E, 8'h9B, 8'h6E, 8'h99, 8'hC2, 8'hB7, 8'h98, 8'hBC,
    8'h8F, 8'h85, 8'h1F, 8'hB4, 8'hF8, 8'h11, 8'h2E, 8'h00, 8'h25, 8'h1C, 8'h2A, 8'h3D, 8'h05, 8'h4F, 8'h7B, 8'hB2,
    8'h32, 8'h90, 8'hAF, 8'h19, 8'hA3, 8'hF7, 8'h73, 8'h9D, 8'h15, 8'h74, 8'hEE, 8'hCA, 8'h9F, 8'h0F, 8'h1B, 8'h75,
    8'h86, 8'h84, 8'h9C, 8'h4A, 8'h97, 8'h1A, 8'h65, 8'hF6, 8'hED, 8'h09, 8'hBB, 8'h26, 8'h83, 8'hEB, 8'h6F, 8'h81,
    8'h04, 8'h6A, 8'h43, 8'h01, 8'h17, 8'hE1, 8'h87, 8'hF5, 8'h8D, 8'hE3, 8'h23, 8'h80, 8'h44, 8'h16, 8'h66, 8'h21,
    8'hFE, 8'hD5, 8'h31, 8'hD9, 8'h35, 8'h18, 8'h02, 8'h64, 8'hF2, 8'hF1, 8'h56, 8'hCD, 8'h82, 8'hC8, 8'hBA, 8'hF0,
    8'hEF, 8'hE9, 8'hE8, 8'hFD, 8'h89, 8'hD7, 8'hC7, 8'hB5, 8'hA4, 8'h2F, 8'h95, 8'h13, 8'h0B, 8'hF3, 8'hE0, 8'h37
  };

  // Multiply by x^n in GF(2^8) mod 0x11D: a chain of n xtime stages.
  function automatic logic [7:0] gf_xn(input logic [7:0] a, input int n);
    logic [7:0] r;
    r = a;
    for (int k = 0; k < n; k++) begin
      r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1D : 8'h00);
    end
    return r;
  endfunction

  // The round counter does not influence key extraction; it is kept on the
  // port list only so the controller interface stays uniform.
  logic unused_counter;
  assign unused_counter = ^counter;

  logic [7:0]       s_byte [16];  // gamma output, index 4t+i = s[t][i]
  logic [KEY_W-1:0] k_next;       // extracted key before registering
  logic [KEY_W-1:0] round_key_d;
  logic [KEY_W-1:0] round_key_q;

  genvar gi;
  generate
    // gamma: one S-box per byte
    for (gi = 0; gi < 16; gi++) begin : g_sbox
      assign s_byte[gi] = SBOX[evolutioned_key[KEY_W-1-8*gi -: 8]];
    end

    // omega + tau: column gi of the gamma output produces row gi of K.
    // Row j of the Vandermonde matrix uses c^j with c = (01, 02, 06, 08).
    for (gi = 0; gi < 4; gi++) begin : g_col
      logic [7:0] s0, s1, s2, s3;
      assign s0 = s_byte[gi];
      assign s1 = s_byte[4+gi];
      assign s2 = s_byte[8+gi];
      assign s3 = s_byte[12+gi];
      // c^0 = (01,01,01,01)
      assign k_next[KEY_W-1-8*(4*gi+0) -: 8] = s0 ^ s1 ^ s2 ^ s3;
      // c^1 = (01,02,06,08)
      assign k_next[KEY_W-1-8*(4*gi+1) -: 8] =
        s0 ^ gf_xn(s1, 1) ^ (gf_xn(s2, 2) ^ gf_xn(s2, 1)) ^ gf_xn(s3, 3);
      // c^2 = (01,04,14,40)
      assign k_next[KEY_W-1-8*(4*gi+2) -: 8] =
        s0 ^ gf_xn(s1, 2) ^ (gf_xn(s2, 4) ^ gf_xn(s2, 2)) ^ gf_xn(s3, 6);
      // c^3 = (01,08,78,3A)
      assign k_next[KEY_W-1-8*(4*gi+3) -: 8] =
        s0 ^ gf_xn(s1, 3)
        ^ (gf_xn(s2, 6) ^ gf_xn(s2, 5) ^ gf_xn(s2, 4) ^ gf_xn(s2, 3))
        ^ (gf_xn(s3, 5) ^ gf_xn(s3, 4) ^ gf_xn(s3, 3) ^ gf_xn(s3, 1));
    end
  endgenerate

  // Capture a freshly extracted key on request, otherwise hold.
  always_comb begin
    round_key_d = round_key_q;
    if (load_key) begin
      round_key_d = k_next;
    end
  end

  // Round-key register; reset wins over a simultaneous load.
  always_ff @(posedge clk) begin
    if (reset) begin
      round_key_q <= '0;
    end else begin
      round_key_q <= round_key_d;
    end
  end

  assign round_key = round_key_q;

endmodule

// File: tb/tb_key_selection.sv
// Bench for key_selection: table-driven load vectors plus hand-written
// multi-cycle sequences, checked through an expected-value queue.
module tb_key_selection;

  logic         clk;
  logic         reset;
  logic [3:0]   counter;
  logic         load_key;
  logic [127:0] evolutioned_key;
  logic [127:0] round_key;

  int checks = 0;
  int errors = 0;

  key_selection #(.KEY_W(128)) dut (
    .clk             (clk),
    .reset           (reset),
    .counter         (counter),
    .load_key        (load_key),
    .evolutioned_key (evolutioned_key),
    .round_key       (round_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [7:0] SBOX_TB [256] = '{
    8'hA7, 8'hD3, 8'hE6, 8'h71, 8'hD0, 8'hAC, 8'h4D, 8'h79, 8'h3A, 8'hC9, 8'h91, 8'hFC, 8'h1E, 8'h47, 8'h54, 8'hBD,
    8'h8C, 8'hA5, 8'h7A, 8'hFB, 8'h63, 8'hB8, 8'hDD, 8'hD4, 8'hE5, 8'hB3, 8'hC5, 8'hBE, 8'hA9, 8'h88, 8'h0C, 8'hA2,
    8'h39, 8'hDF, 8'h29, 8'hDA, 8'h2B, 8'hA8, 8'hCB, 8'h4C, 8'h4B, 8'h22, 8'hAA, 8'h24, 8'h41, 8'h70, 8'hA6, 8'hF9,
    8'h5A, 8'hE2, 8'hB0, 8'h36, 8'h7D, 8'hE4, 8'h33, 8'hFF, 8'h60, 8'h20, 8'h08, 8'h8B, 8'h5E, 8'hAB, 8'h7F, 8'h78,
    8'h7C, 8'h2C, 8'h57, 8'hD2, 8'hDC, 8'h6D, 8'h7E, 8'h0D, 8'h53, 8'h94, 8'hC3, 8'h28, 8'h27, 8'h06, 8'h5F, 8'hAD,
    8'h67, 8'h5C, 8'h55, 8'h48, 8'h0E, 8'h52, 8'hEA, 8'h42, 8'h5B, 8'h5D, 8'h30, 8'h58, 8'h51, 8'h59, 8'h3C, 8'h4E,
    8'h38, 8'h8A, 8'h72, 8'h14, 8'hE7, 8'hC6, 8'hDE, 8'h50, 8'h8E, 8'h92, 8'hD1, 8'h77, 8'h93, 8'h45, 8'h9A, 8'hCE,
    8'h2D, 8'h03, 8'h62, 8'hB6, 8'hB9, 8'hBF, 8'h96, 8'h6B, 8'h3F, 8'h07, 8'h12, 8'hAE, 8'h40, 8'h34, 8'h46, 8'h3E,
    8'hDB, 8'hCF, 8'hEC, 8'hCC, 8'hC1, 8'hA1, 8'hC0, 8'hD6, 8'h1D, 8'hF4, 8'h61, 8'h3B, 8'h10, 8'hD8, 8'h68, 8'hA0,
    8'hB1, 8'h0A, 8'h69, 8'h6C, 8'h49, 8'hFA, 8'h76, 8'hC4, 8'h9E, 8'h9B, 8'h6E, 8'h99, 8'hC2, 8'hB7, 8'h98, 8'hBC,
    8'h8F, 8'h85, 8'h1F, 8'hB4, 8'hF8, 8'h11, 8'h2E, 8'h00, 8'h25, 8'h1C, 8'h2A, 8'h3D, 8'h05, 8'h4F, 8'h7B, 8'hB2,
    8'h32, 8'h90, 8'hAF, 8'h19, 8'hA3, 8'hF7, 8'h73, 8'h9D, 8'h15, 8'h74, 8'hEE, 8'hCA, 8'h9F, 8'h0F, 8'h1B, 8'h75,
    8'h86, 8'h84, 8'h9C, 8'h4A, 8'h97, 8'h1A, 8'h65, 8'hF6, 8'hED, 8'h09, 8'hBB, 8'h26, 8'h83, 8'hEB, 8'h6F, 8'h81,
    8'h04, 8'h6A, 8'h43, 8'h01, 8'h17, 8'hE1, 8'h87, 8'hF5, 8'h8D, 8'hE3, 8'h23, 8'h80, 8'h44, 8'h16, 8'h66, 8'h21,
    8'hFE, 8'hD5, 8'h31, 8'hD9, 8'h35, 8'h18, 8'h02, 8'h64, 8'hF2, 8'hF1, 8'h56, 8'hCD, 8'h82, 8'hC8, 8'hBA, 8'hF0,
    8'hEF, 8'hE9, 8'hE8, 8'hFD, 8'h89, 8'hD7, 8'hC7, 8'hB5, 8'hA4, 8'h2F, 8'h95, 8'h13, 8'h0B, 8'hF3, 8'hE0, 8'h37
  };

  // Generic shift-and-add GF(2^8) multiply, polynomial 0x11D.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] aa;
    r = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) r = r ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1D : 8'h00);
    end
    return r;
  endfunction

  // Reference extraction straight from the definition: K[i][j] = XOR_t c_t^j * S(kappa[t][i]).
  function automatic logic [127:0] kext(input logic [127:0] key);
    logic [7:0]   s [16];
    logic [7:0]   c [4];
    logic [7:0]   cp;
    logic [7:0]   acc;
    logic [127:0] r;
    c[0] = 8'h01; c[1] = 8'h02; c[2] = 8'h06; c[3] = 8'h08;
    r = '0;
    for (int b = 0; b < 16; b++) s[b] = SBOX_TB[key[127-8*b -: 8]];
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        acc = 8'h00;
        for (int t = 0; t < 4; t++) begin
          cp = 8'h01;
          for (int e = 0; e < j; e++) cp = gf_mul(cp, c[t]);
          acc = acc ^ gf_mul(cp, s[4*t+i]);
        end
        r[127-8*(4*i+j) -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  typedef struct {
    logic         rst;
    logic         ld;
    logic [3:0]   cnt;
    logic [127:0] key;
    logic [127:0] exp;
  } vec_t;

  typedef struct {
    string        tag;
    logic [127:0] exp;
  } sb_t;

  sb_t          sb_q [$];
  logic [127:0] held;   // model of the round-key register

  function automatic logic [127:0] exp_for(input logic rst, input logic ld, input logic [127:0] key);
    if (rst) return '0;
    if (ld) return kext(key);
    return held;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input logic rst, input logic ld, input logic [3:0] cnt,
                       input logic [127:0] key, input logic [127:0] exp, input string tag);
    sb_t e;
    @(negedge clk);
    reset = rst;
    load_key = ld;
    counter = cnt;
    evolutioned_key = key;
    held = exp;
    sb_q.push_back('{tag, exp});
    @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, round_key=%h", tag, round_key);
    end else begin
      e = sb_q.pop_front();
      if (round_key !== e.exp) begin
        errors++;
        $display("FAIL %s: round_key=%h expected=%h", e.tag, round_key, e.exp);
      end else begin
        $display("ok   %s: round_key=%h", e.tag, round_key);
      end
    end
  endtask

  task automatic step(input logic rst, input logic ld, input logic [3:0] cnt,
                      input logic [127:0] key, input string tag);
    apply(rst, ld, cnt, key, exp_for(rst, ld, key), tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t         vecs [16];
    logic [127:0] ka, kb, kc, zexp;
    logic [7:0]   z1, z2, z3;

    held = '0;
    reset = 1'b1;
    load_key = 1'b0;
    counter = 4'd0;
    evolutioned_key = '0;

    for (int v = 0; v < 16; v++) begin
      vecs[v].rst = 1'b0;
      vecs[v].ld  = 1'b1;
      vecs[v].cnt = 4'($urandom_range(0, 15));
      vecs[v].key = rand128();
      vecs[v].exp = kext(vecs[v].key);
    end

    // Reset dominates a simultaneous load, then a normal load follows.
    ka = 128'h0123456789ABCDEF_FEDCBA9876543210;
    step(1'b1, 1'b1, 4'd0, ka, "reset0");
    step(1'b1, 1'b1, 4'd1, ka, "reset1");
    step(1'b0, 1'b1, 4'd2, ka, "load_after_reset");

    // All-zero key: column 0 cancels, other columns are S(00)=A7 times c-sums.
    step(1'b0, 1'b1, 4'd3, '0, "zero_key");
    z1 = gf_mul(8'hA7, 8'h0D);
    z2 = gf_mul(8'hA7, 8'h51);
    z3 = gf_mul(8'hA7, 8'h4B);
    zexp = {4{8'h00, z1, z2, z3}};
    checks++;
    if (round_key !== zexp) begin
      errors++;
      $display("FAIL zero_key_bytes: round_key=%h expected=%h", round_key, zexp);
    end

    // Hold: load A, then change the key with load low for five cycles.
    ka = rand128();
    kb = rand128();
    step(1'b0, 1'b1, 4'd4, ka, "hold_load_a");
    for (int n = 0; n < 5; n++) step(1'b0, 1'b0, 4'(5 + n), kb, "hold_a");
    step(1'b0, 1'b1, 4'd10, kb, "load_b");

    // Table-driven regression of random keys, one strobe each.
    for (int v = 0; v < 16; v++) begin
      apply(vecs[v].rst, vecs[v].ld, vecs[v].cnt, vecs[v].key, vecs[v].exp, $sformatf("vec%0d", v));
      step(1'b0, 1'b0, 4'd0, rand128(), $sformatf("vec%0d_idle", v));
    end

    // Counter independence, including a free-running wrap.
    kc = rand128();
    step(1'b0, 1'b1, 4'd0, kc, "cnt0");
    step(1'b0, 1'b1, 4'd7, kc, "cnt7");
    step(1'b0, 1'b1, 4'd15, kc, "cnt15");
    for (int n = 0; n < 20; n++) step(1'b0, 1'b1, 4'(n), kc, $sformatf("cnt_run%0d", n));

    // Continuous load with a new key every cycle, then retention.
    for (int n = 0; n < 4; n++) step(1'b0, 1'b1, 4'(n), rand128(), $sformatf("cont%0d", n));
    step(1'b0, 1'b0, 4'd4, rand128(), "cont_retain0");
    step(1'b0, 1'b0, 4'd5, rand128(), "cont_retain1");

    // Reset mid-operation, then a clean load.
    step(1'b1, 1'b0, 4'd6, rand128(), "mid_reset");
    step(1'b0, 1'b0, 4'd7, rand128(), "mid_reset_hold");
    step(1'b0, 1'b1, 4'd8, ka, "reload_a");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
